// File: rtl/program_loader.sv
// Packs big-endian byte pairs from the UART receiver into instruction words,
// validates each opcode and writes the words sequentially into program RAM.
module program_loader #(
    parameter int unsigned NB_OPCODE  = 5,
    parameter int unsigned NB_OPERAND = 11,
    parameter int unsigned NB_BYTE    = 8,
    parameter int unsigned NB_ADDR    = 11,
    parameter int unsigned RAM_DEPTH  = 2048
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic [NB_BYTE-1:0]              i_rx_data,
    input  logic                            i_rx_valid,
    output logic                            o_wr_enb_prog,
    output logic [NB_ADDR-1:0]              o_wr_addr,
    output logic [NB_OPCODE+NB_OPERAND-1:0] o_wr_data,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_error,
    output logic [1:0]                      o_error_code,
    output logic [NB_ADDR:0]                o_word_count
);

    localparam int unsigned NB_WORD = NB_OPCODE + NB_OPERAND;
    localparam logic [NB_OPCODE-1:0] OPC_HALT = '0;
    localparam logic [NB_OPCODE-1:0] OPC_MAX  = NB_OPCODE'(7);
    localparam logic [NB_ADDR-1:0]   LAST_ADDR = NB_ADDR'(RAM_DEPTH - 1);
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OPCODE   = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HIGH,
        WAIT_LOW,
        DONE,
        ERROR
    } state_t;

    state_t                 state_q,    state_d;
    logic [NB_BYTE-1:0]     hi_q,       hi_d;
    logic [NB_ADDR-1:0]     addr_q,     addr_d;
    logic                   wr_enb_q,   wr_enb_d;
    logic [NB_ADDR-1:0]     wr_addr_q,  wr_addr_d;
    logic [NB_WORD-1:0]     wr_data_q,  wr_data_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic                   error_q,    error_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [NB_ADDR:0]       count_q,    count_d;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        wr_enb_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        count_d    = count_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    state_d    = WAIT_HIGH;
                    addr_d     = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    count_d    = '0;
                end
            end
            WAIT_HIGH: begin
                if (i_rx_valid) begin
                    if (i_rx_data[NB_BYTE-1 -: NB_OPCODE] > OPC_MAX) begin
                        state_d    = ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_OPCODE;
                    end else begin
                        hi_d    = i_rx_data;
                        state_d = WAIT_LOW;
                    end
                end
            end
            WAIT_LOW: begin
                if (i_rx_valid) begin
                    wr_enb_d  = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = {hi_q, i_rx_data};
                    addr_d    = addr_q + NB_ADDR'(1);
                    count_d   = count_q + (NB_ADDR+1)'(1);
                    // HALT wins over overflow when it lands in the last slot
                    if (hi_q[NB_BYTE-1 -: NB_OPCODE] == OPC_HALT) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (addr_q == LAST_ADDR) begin
                        state_d    = ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_OVERFLOW;
                    end else begin
                        state_d = WAIT_HIGH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            addr_q     <= '0;
            wr_enb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            wr_enb_q   <= wr_enb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            count_q    <= count_d;
        end
    end

    assign o_wr_enb_prog = wr_enb_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_error       = error_q;
    assign o_error_code  = err_code_q;
    assign o_word_count  = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a byte-level reference model checked every
// cycle, plus literal expectations on the captured write log for each scenario.
module tb_program_loader;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        wr_enb;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy, done, error;
    logic [1:0]  error_code;
    logic [11:0] word_count;

    program_loader #(.RAM_DEPTH(DEPTH)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_wr_enb_prog (wr_enb),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (error),
        .o_error_code  (error_code),
        .o_word_count  (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a load is a sequence of accepted bytes; every second
    // byte completes a word at address = words already stored.
    bit          m_loading = 0;
    int          m_nbytes  = 0;
    int          m_words   = 0;
    logic [7:0]  m_hi      = '0;
    logic        e_wr = 0, e_busy = 0, e_done = 0, e_err = 0;
    logic [10:0] e_addr  = '0;
    logic [15:0] e_data  = '0;
    logic [1:0]  e_code  = '0;
    logic [11:0] e_count = '0;
    bit          cmp_en  = 0;

    always @(posedge clk) begin
        logic [15:0] word;
        e_wr = 0;
        if (rst) begin
            m_loading = 0; m_nbytes = 0; m_words = 0; m_hi = '0;
            e_addr = '0; e_data = '0; e_done = 0; e_err = 0; e_code = '0; e_count = '0;
        end else if (!m_loading) begin
            if (start) begin
                m_loading = 1; m_nbytes = 0; m_words = 0;
                e_done = 0; e_err = 0; e_code = '0; e_count = '0;
            end
        end else if (rx_valid) begin
            if (m_nbytes % 2 == 0) begin
                if (rx_data[7:3] > 5'd7) begin
                    m_loading = 0; e_err = 1; e_code = 2'b01;
                end else begin
                    m_hi = rx_data; m_nbytes++;
                end
            end else begin
                word = {m_hi, rx_data};
                e_wr = 1; e_addr = 11'(m_words); e_data = word;
                m_words++; m_nbytes++;
                e_count = 12'(m_words);
                if (word[15:11] == 5'd0) begin
                    m_loading = 0; e_done = 1;
                end else if (m_words == DEPTH) begin
                    m_loading = 0; e_err = 1; e_code = 2'b10;
                end
            end
        end
        e_busy = m_loading;
        cmp_en = 1;
    end

    logic [26:0] wlog[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("wr_enb", 32'(wr_enb), 32'(e_wr));
            chk("wr_addr", 32'(wr_addr), 32'(e_addr));
            chk("wr_data", 32'(wr_data), 32'(e_data));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("error", 32'(error), 32'(e_err));
            chk("error_code", 32'(error_code), 32'(e_code));
            chk("word_count", 32'(word_count), 32'(e_count));
        end
        if (wr_enb === 1'b1) wlog.push_back({wr_addr, wr_data});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data = b; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        repeat (gap) cyc();
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0; cyc();
    endtask

    task automatic chk_log(input string name, input int idx, input logic [10:0] a, input logic [15:0] d);
        if (idx < wlog.size()) chk(name, 32'(wlog[idx]), 32'({a, d}));
        else chk({name, "_missing"}, 32'(wlog.size()), 32'(idx + 1));
    endtask

    task automatic chk_final(input string name, input int nw, input logic dn, input logic er,
                             input logic [1:0] code, input logic [11:0] cnt);
        chk({name, "_nwrites"}, 32'(wlog.size()), 32'(nw));
        chk({name, "_done"}, 32'(done), 32'(dn));
        chk({name, "_error"}, 32'(error), 32'(er));
        chk({name, "_code"}, 32'(error_code), 32'(code));
        chk({name, "_count"}, 32'(word_count), 32'(cnt));
        chk({name, "_busy"}, 32'(busy), 32'(0));
    endtask

    logic [7:0] normal_stream [6] = '{8'h18, 8'h05, 8'h28, 8'h03, 8'h00, 8'h00};

    initial begin
        repeat (3) cyc();
        chk("reset_outputs", 32'({wr_enb, wr_addr, wr_data, busy, done, error}), 32'(0));
        chk("reset_count", 32'({error_code, word_count}), 32'(0));
        rst = 1'b0;
        cyc();

        // normal load, one idle cycle between bytes; trailing byte in DONE is ignored
        wlog.delete();
        do_start();
        foreach (normal_stream[i]) send(normal_stream[i], 1);
        send(8'h28, 1);
        cyc();
        chk_log("normal_w0", 0, 11'd0, 16'h1805);
        chk_log("normal_w1", 1, 11'd1, 16'h2803);
        chk_log("normal_w2", 2, 11'd2, 16'h0000);
        chk_final("normal", 3, 1'b1, 1'b0, 2'b00, 12'd3);

        // illegal opcode, later bytes ignored
        wlog.delete();
        do_start();
        send(8'h18, 1); send(8'h05, 1); send(8'h40, 1);
        send(8'h28, 1); send(8'h03, 1);
        cyc();
        chk_log("illegal_w0", 0, 11'd0, 16'h1805);
        chk_final("illegal", 1, 1'b0, 1'b1, 2'b01, 12'd1);

        // overflow at RAM_DEPTH=4, fifth word ignored
        wlog.delete();
        do_start();
        repeat (5) begin send(8'h28, 0); send(8'h01, 1); end
        cyc();
        for (int i = 0; i < 4; i++) chk_log("overflow_w", i, 11'(i), 16'h2801);
        chk_final("overflow", 4, 1'b0, 1'b1, 2'b10, 12'd4);

        // back-to-back bytes
        wlog.delete();
        do_start();
        foreach (normal_stream[i]) send(normal_stream[i], 0);
        cyc(); cyc();
        chk_log("b2b_w0", 0, 11'd0, 16'h1805);
        chk_log("b2b_w1", 1, 11'd1, 16'h2803);
        chk_log("b2b_w2", 2, 11'd2, 16'h0000);
        chk_final("b2b", 3, 1'b1, 1'b0, 2'b00, 12'd3);

        // reset mid-load
        do_start();
        send(8'h18, 0);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("midreset_outputs", 32'({wr_enb, wr_addr, wr_data, busy, done, error}), 32'(0));
        chk("midreset_count", 32'({error_code, word_count}), 32'(0));
        cyc();
        wlog.delete();
        do_start();
        send(8'h00, 1); send(8'h00, 1);
        cyc();
        chk_log("midreset_w0", 0, 11'd0, 16'h0000);
        chk_final("midreset", 1, 1'b1, 1'b0, 2'b00, 12'd1);

        // i_start pulse in WAIT_LOW has no effect
        wlog.delete();
        do_start();
        send(8'h28, 1); send(8'h01, 1);
        send(8'h18, 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("busy_start_busy", 32'(busy), 32'(1));
        send(8'h05, 1);
        send(8'h00, 0); send(8'h00, 1);
        cyc();
        chk_log("busy_start_w0", 0, 11'd0, 16'h2801);
        chk_log("busy_start_w1", 1, 11'd1, 16'h1805);
        chk_log("busy_start_w2", 2, 11'd2, 16'h0000);
        chk_final("busy_start", 3, 1'b1, 1'b0, 2'b00, 12'd3);

        // HALT landing in the last slot completes rather than overflowing
        wlog.delete();
        do_start();
        repeat (3) begin send(8'h28, 0); send(8'h01, 0); end
        send(8'h00, 0); send(8'h07, 1);
        cyc();
        chk_log("halt_last_w3", 3, 11'd3, 16'h0007);
        chk_final("halt_last", 4, 1'b1, 1'b0, 2'b00, 12'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
